// File: rtl/round_sat_pack.sv
// Shift/saturate stage behind the rounding multiplier: drops SHIFT LSBs, clips to OUT_W,
// and buffers through S1 plus a 2-entry FIFO so a back-pressuring sink can stall it.
module round_sat_pack #(
    parameter int IN_W  = 44,
    parameter int SHIFT = 4,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IN_W-1:0]  DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic [OUT_W-1:0] DOUT,
    output logic             DOUT_SAT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    input  logic             CLR_STATS,
    output logic             SAT_STICKY,
    output logic [CNT_W-1:0] SAT_CNT
);
    localparam int S_W = IN_W - SHIFT;

    logic [S_W-1:0]     w_s;
    logic [S_W-OUT_W:0] w_hi;
    logic               w_sat;
    logic [OUT_W-1:0]   w_res;
    logic               w_unused_lsb;
    logic               w_room, w_in_xfer, w_push, w_pop, w_evt;

    logic               r_s1_vld;
    logic [OUT_W-1:0]   r_s1_dat;
    logic               r_s1_sat;
    logic [OUT_W-1:0]   r_mem_dat [2];
    logic               r_mem_sat [2];
    logic               r_wp, r_rp;
    logic [1:0]         r_cnt;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_sat_cnt;

    // Dropped LSBs are already rounded upstream and simply discarded.
    generate
        if (SHIFT > 0) begin : g_lsb
            assign w_unused_lsb = ^DIN[SHIFT-1:0];
        end else begin : g_nolsb
            assign w_unused_lsb = 1'b0;
        end
    endgenerate

    // In range iff every bit from the output sign upward matches.
    assign w_s   = DIN[IN_W-1:SHIFT];
    assign w_hi  = w_s[S_W-1:OUT_W-1];
    assign w_sat = !((&w_hi) || !(|w_hi));
    assign w_res = !w_sat        ? w_s[OUT_W-1:0] :
                   w_s[S_W-1]    ? {1'b1, {(OUT_W-1){1'b0}}} :
                                   {1'b0, {(OUT_W-1){1'b1}}};

    assign w_room     = (r_cnt != 2'd2);
    assign DIN_READY  = !RST && (!r_s1_vld || w_room);
    assign w_in_xfer  = DIN_VALID && DIN_READY;
    assign w_push     = r_s1_vld && w_room;
    assign DOUT_VALID = (r_cnt != 2'd0);
    assign w_pop      = DOUT_VALID && DOUT_READY;
    assign DOUT       = r_mem_dat[r_rp];
    assign DOUT_SAT   = r_mem_sat[r_rp];
    assign w_evt      = w_pop && DOUT_SAT;
    assign SAT_STICKY = r_sticky;
    assign SAT_CNT    = r_sat_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_sat <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_vld <= 1'b1;
            r_s1_dat <= w_res;
            r_s1_sat <= w_sat;
        end else if (w_push) begin
            r_s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem_dat[0] <= '0;
            r_mem_dat[1] <= '0;
            r_mem_sat[0] <= 1'b0;
            r_mem_sat[1] <= 1'b0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_dat[r_wp] <= r_s1_dat;
                r_mem_sat[r_wp] <= r_s1_sat;
                r_wp            <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A clear coincident with an event leaves that event counted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sticky  <= 1'b0;
            r_sat_cnt <= '0;
        end else if (CLR_STATS) begin
            r_sticky  <= w_evt;
            r_sat_cnt <= w_evt ? CNT_W'(1) : '0;
        end else if (w_evt) begin
            r_sticky <= 1'b1;
            if (!(&r_sat_cnt))
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_round_sat_pack.sv
// Scoreboard bench for round_sat_pack: driver queues expectations on each accepted
// input, monitor pops and compares on each output transfer.
module tb_round_sat_pack;
    typedef struct {
        logic [43:0] din;
        logic [15:0] dout;
        logic        sat;
    } stim_t;
    typedef struct {
        logic [15:0] dout;
        logic        sat;
        int          tacc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [43:0] DIN;
    logic        DIN_VALID, DIN_READY;
    logic [15:0] DOUT;
    logic        DOUT_SAT, DOUT_VALID, DOUT_READY, CLR_STATS, SAT_STICKY;
    logic [15:0] SAT_CNT;

    logic [43:0] b_din;
    logic        b_vld, b_rdy_o, b_dsat, b_dvld, b_clr, b_sticky;
    logic [15:0] b_dout;
    logic [3:0]  b_cnt;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_chk = 0, n_pass = 0;
    int    cyc = 0, acc_cnt = 0, pop_cnt = 0, mdl_sat = 0;
    int    vld_pct = 100;
    bit    rdy_rand = 0, rdy_fix = 1, lat_chk = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    round_sat_pack #(.IN_W(44), .SHIFT(4), .OUT_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .DOUT(DOUT), .DOUT_SAT(DOUT_SAT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .CLR_STATS(CLR_STATS), .SAT_STICKY(SAT_STICKY), .SAT_CNT(SAT_CNT)
    );

    round_sat_pack #(.IN_W(44), .SHIFT(4), .OUT_W(16), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .DIN(b_din), .DIN_VALID(b_vld), .DIN_READY(b_rdy_o),
        .DOUT(b_dout), .DOUT_SAT(b_dsat), .DOUT_VALID(b_dvld), .DOUT_READY(1'b1),
        .CLR_STATS(b_clr), .SAT_STICKY(b_sticky), .SAT_CNT(b_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: arithmetic shift then clip to signed 16 bits.
    function automatic stim_t mk(input logic [43:0] d);
        stim_t  s;
        longint v;
        v = longint'($signed(d)) >>> 4;
        s.din = d;
        if (v > 32767)       begin s.dout = 16'h7FFF; s.sat = 1'b1; end
        else if (v < -32768) begin s.dout = 16'h8000; s.sat = 1'b1; end
        else                 begin s.dout = v[15:0];  s.sat = 1'b0; end
        return s;
    endfunction

    function automatic stim_t st(input logic [43:0] d, input logic [15:0] o, input logic s);
        stim_t r;
        r.din = d; r.dout = o; r.sat = s;
        return r;
    endfunction

    // Driver: presents queued stimulus, records expectation on each accepted transfer.
    initial begin
        DIN = '0; DIN_VALID = 1'b0; DOUT_READY = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (stim_q.size() != 0 && !RST && $urandom_range(99) < vld_pct) begin
                DIN = stim_q[0].din; DIN_VALID = 1'b1;
            end else begin
                DIN_VALID = 1'b0;
            end
            DOUT_READY = rdy_rand ? 1'($urandom_range(1)) : rdy_fix;
            @(negedge CLK);
            if (lat_chk && DIN_VALID) chk("din_ready_held", DIN_READY, 1);
            if (DIN_VALID && DIN_READY && stim_q.size() != 0) begin
                exp_t e;
                e.dout = stim_q[0].dout; e.sat = stim_q[0].sat; e.tacc = cyc + 1;
                exp_q.push_back(e);
                void'(stim_q.pop_front());
                acc_cnt++;
            end
        end
    end

    // Monitor: compares every output transfer against the head expectation.
    always @(negedge CLK) begin
        if (!RST && DOUT_VALID && DOUT_READY) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got DOUT=%0h with empty scoreboard (t=%0t)", DOUT, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", DOUT, e.dout);
                chk("dout_sat", DOUT_SAT, e.sat);
                if (lat_chk) chk("latency", cyc - e.tacc, 1);
                pop_cnt++;
                if (e.sat) mdl_sat++;
            end
        end
    end

    task automatic drain(input int limit);
        int t;
        for (t = 0; t < limit; t++) begin
            @(negedge CLK); #1;
            if (stim_q.size() == 0 && exp_q.size() == 0) break;
        end
        if (t == limit) begin
            n_chk++;
            $display("FAIL drain_timeout: stim left %0d exp left %0d", stim_q.size(), exp_q.size());
        end
    endtask

    initial begin
        int p0, a0, n;
        RST = 1'b1; CLR_STATS = 1'b0;
        b_din = '0; b_vld = 1'b0; b_clr = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_dout_valid", DOUT_VALID, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_dout_sat", DOUT_SAT, 0);
        chk("rst_sat_cnt", SAT_CNT, 0);
        chk("rst_sticky", SAT_STICKY, 0);
        chk("rst_din_ready", DIN_READY, 0);
        RST = 1'b0;
        #1 chk("rel_din_ready", DIN_READY, 1);

        // Basic latency/throughput
        lat_chk = 1'b1;
        stim_q.push_back(st(44'h00000000020, 16'h0002, 1'b0));
        stim_q.push_back(st(44'hFFFFFFFFFE0, 16'hFFFE, 1'b0));
        drain(20);
        lat_chk = 1'b0;

        // Saturation boundaries
        stim_q.push_back(st(44'h000_0007_FFF0, 16'h7FFF, 1'b0));
        stim_q.push_back(st(44'h000_0008_0000, 16'h7FFF, 1'b1));
        stim_q.push_back(st(44'hFFF_FFF8_0000, 16'h8000, 1'b0));
        stim_q.push_back(st(44'hFFF_FFF7_FFF0, 16'h8000, 1'b1));
        drain(20);
        repeat (2) @(negedge CLK);
        chk("bnd_sat_cnt", SAT_CNT, 2);
        chk("bnd_sticky", SAT_STICKY, 1);

        // Back-pressure: three held, then gapless drain
        rdy_fix = 1'b0;
        a0 = acc_cnt;
        for (int i = 1; i <= 5; i++) stim_q.push_back(st(44'(i << 4), 16'(i), 1'b0));
        repeat (8) @(negedge CLK);
        #1;
        chk("bp_accepted", acc_cnt - a0, 3);
        chk("bp_din_ready", DIN_READY, 0);
        chk("bp_head", DOUT, 16'h0001);
        chk("bp_head_valid", DOUT_VALID, 1);
        p0 = pop_cnt;
        rdy_fix = 1'b1;
        repeat (5) @(negedge CLK);
        #1 chk("bp_gapless", pop_cnt - p0, 5);
        drain(20);

        // Random valid/ready
        CLR_STATS = 1'b1;
        @(negedge CLK) CLR_STATS = 1'b0;
        mdl_sat = 0;
        for (int i = 0; i < 10000; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            if (r[63]) stim_q.push_back(mk(r[43:0]));
            else       stim_q.push_back(mk(44'($signed(r[20:0]))));
        end
        vld_pct = 50; rdy_rand = 1'b1;
        drain(60000);
        vld_pct = 100; rdy_rand = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rand_sat_cnt", SAT_CNT, 16'(mdl_sat));

        // Narrow counter saturation and clear interaction
        n = 0;
        for (int t = 0; t < 60 && n < 17; t++) begin
            @(negedge CLK);
            b_din = 44'h7FF_FFFF_FFFF; b_vld = 1'b1;
            if (b_rdy_o) n++;
        end
        @(negedge CLK) b_vld = 1'b0;
        chk("b_accepted", n, 17);
        repeat (4) @(negedge CLK);
        chk("b_cnt_sat", b_cnt, 4'hF);
        chk("b_sticky", b_sticky, 1);
        b_vld = 1'b1;
        @(negedge CLK) b_vld = 1'b0;
        for (int t = 0; t < 10 && !b_dvld; t++) @(negedge CLK);
        chk("b_18th_valid", b_dvld, 1);
        chk("b_18th_sat", b_dsat, 1);
        b_clr = 1'b1;
        @(negedge CLK) b_clr = 1'b0;
        #1;
        chk("b_clr_evt_cnt", b_cnt, 1);
        chk("b_clr_evt_sticky", b_sticky, 1);
        @(negedge CLK) b_clr = 1'b1;
        @(negedge CLK) b_clr = 1'b0;
        #1;
        chk("b_clr_cnt", b_cnt, 0);
        chk("b_clr_sticky", b_sticky, 0);

        // Async reset with three samples held
        rdy_fix = 1'b0;
        for (int i = 0; i < 5; i++) stim_q.push_back(mk(44'h100 + 44'(i << 8)));
        repeat (6) @(negedge CLK);
        chk("pre_rst_valid", DOUT_VALID, 1);
        @(posedge CLK); #3;
        RST = 1'b1;
        stim_q.delete(); exp_q.delete();
        #1;
        chk("arst_dout_valid", DOUT_VALID, 0);
        chk("arst_din_ready", DIN_READY, 0);
        repeat (2) @(negedge CLK);
        mdl_sat = 0;
        RST = 1'b0; rdy_fix = 1'b1;
        #1;
        chk("post_sat_cnt", SAT_CNT, 0);
        chk("post_sticky", SAT_STICKY, 0);
        chk("post_valid", DOUT_VALID, 0);
        lat_chk = 1'b1;
        stim_q.push_back(st(44'h00000000ABC, 16'h00AB, 1'b0));
        drain(20);
        repeat (4) @(negedge CLK);
        lat_chk = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/round_sat_pack.md
Name: round_sat_pack

Overview:
- Downstream consumer of the DSP48E convergent-rounding multiplier stage.
- Takes the full-width rounded product word and arithmetically drops SHIFT already-rounded fractional LSBs.
- Saturates the result to a signed OUT_W sample and delivers it over a valid/ready stream.
- Decouples the free-running DSP pipeline from a back-pressuring sink (packer/FIFO/DAC interface) and keeps saturation statistics.

Parameters:
- IN_W, 44, signed input width (matches rounded product output width).
- SHIFT, 4, number of LSBs discarded by arithmetic right shift; 0 <= SHIFT < IN_W-OUT_W.
- OUT_W, 16, signed output sample width.
- CNT_W, 16, width of saturation event counter.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DIN  in  IN_W  signed two's-complement rounded product.
- DIN_VALID  in  1  DIN holds a sample.
- DIN_READY  out  1  block accepts DIN this cycle; transfer = DIN_VALID & DIN_READY.
- DOUT  out  OUT_W  signed saturated sample.
- DOUT_SAT  out  1  DOUT was clipped; aligned with DOUT.
- DOUT_VALID  out  1  DOUT/DOUT_SAT valid.
- DOUT_READY  in  1  sink accepts; transfer = DOUT_VALID & DOUT_READY.
- CLR_STATS  in  1  synchronous clear of SAT_STICKY and SAT_CNT.
- SAT_STICKY  out  1  set on any saturated output transfer.
- SAT_CNT  out  CNT_W  count of saturated output transfers, saturating at all-ones.

Behaviour:
- Reset (async, RST=1): S1 empty, FIFO empty, DOUT=0, DOUT_SAT=0, DOUT_VALID=0, SAT_STICKY=0, SAT_CNT=0. DIN_READY=0 while RST high, 1 in the first cycle after release. Reset mid-stream discards all in-flight samples; no partial output.
- Datapath:
  - s = DIN >>> SHIFT, sign-extended, width IN_W-SHIFT.
  - s > 2^(OUT_W-1)-1 -> 0x7FF..F, sat=1.
  - s < -2^(OUT_W-1) -> 0x800..0, sat=1.
  - Otherwise s[OUT_W-1:0], sat=0.
  - Exact boundary values pass unclipped. No further rounding: dropped bits are discarded (upstream already rounded).
- Structure: compute register S1 (result + sat + valid), then 2-entry output FIFO. DOUT/DOUT_SAT are driven by the FIFO head register.
- S1 move to FIFO when s1_valid & (fifo_count < 2), using the registered count only.
- DIN_READY = !s1_valid | (fifo_count < 2).
  - Combinational from registered state only.
  - No path from DOUT_READY to DIN_READY.
- FIFO:
  - Push from S1 and pop by DOUT transfer in the same cycle are allowed; count unchanged.
  - Pop when empty cannot occur (DOUT_VALID = count != 0).
  - Push when count==2 never occurs, by the rule above.
  - Pointers wrap modulo 2.
- Latency: a sample accepted at edge k is on DOUT with DOUT_VALID=1 after edge k+1 (FIFO empty, no stall).
- Throughput: 1 sample/cycle when DOUT_READY is held high.
- Capacity: with DOUT_READY=0, 3 samples are held (S1 + 2 FIFO); DIN_READY then 0.
- DOUT/DOUT_SAT hold stable while DOUT_VALID=1 and DOUT_READY=0.
- Statistics event = DOUT transfer with DOUT_SAT=1.
  - Event: SAT_STICKY<=1; SAT_CNT<=SAT_CNT+1 unless all-ones (holds).
  - CLR_STATS alone: both cleared to 0.
  - CLR_STATS and event in the same cycle: SAT_STICKY=1, SAT_CNT=1.
- Order preserved; no sample dropped or duplicated under any valid/ready pattern.

Test Plan:
- Reset release, DOUT_READY=1; DIN=44'h00000000020 then 44'hFFFFFFFFFE0, consecutive cycles -> DOUT=16'h0002 then 16'hFFFE, one cycle after each acceptance, DOUT_SAT=0, DIN_READY stays 1.
- Boundaries, SHIFT=4:
  - DIN=44'h000_0007_FFF0 -> 16'h7FFF, sat=0.
  - DIN=44'h000_0008_0000 -> 16'h7FFF, sat=1.
  - DIN=44'hFFF_FFF8_0000 -> 16'h8000, sat=0.
  - DIN=44'hFFF_FFF7_FFF0 -> 16'h8000, sat=1.
  - End state: SAT_CNT=2, SAT_STICKY=1.
- Back-pressure: DOUT_READY=0, stream 5 samples 1..5 (<<4) -> exactly 3 accepted, DIN_READY=0 after the third. Raise DOUT_READY -> DOUT sequence 1,2,3,4,5 with no gaps after refill and no loss.
- Random DIN_VALID/DOUT_READY (50% each), 10k random DIN -> scoreboard matches the shift/saturate model in order; SAT_CNT equals the model count.
- CNT_W=4: 17 saturating transfers -> SAT_CNT=4'hF. CLR_STATS coincident with an 18th saturating transfer -> SAT_CNT=1, SAT_STICKY=1. CLR_STATS alone -> 0, 0.
- Assert RST asynchronously (mid-cycle) with 3 samples held -> DOUT_VALID=0 and DIN_READY=0 immediately. After release, counters are 0, the old samples never appear, and a new sample emerges with 1-cycle latency.
